instr_fetch_unit: RTL and testbench

//  Parametrised fetch front end for the CPU core. Replaces the bare PC/instruction-memory pairing with a PC generator,
//  a pipelined request to a 1-cycle-latency instruction memory, and a DEPTH-entry prefetch queue.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit_fifo.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared defaults and constants for the instruction fetch front end.
// Contents: default widths, reset PC, PC step, prefetch depth and the NOP encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_W   = 32;
    localparam int unsigned IFU_INSTR_W  = 32;
    localparam int unsigned IFU_DEPTH    = 4;
    localparam int unsigned IFU_PC_STEP  = 4;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    // Occupancy counter width for a queue of the given depth (holds 0..depth).
    function automatic int unsigned ifu_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Purpose : bundles the memory request, redirect and decode handshake signals of the fetch unit.
// Signals : imem_req/imem_addr/imem_rdata   instruction memory port (1-cycle read latency)
//           redirect_valid/redirect_pc      branch/jump restart
//           if_valid/if_ready/if_pc/if_instr decode handshake, q_count queue occupancy
// Modports: master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 3
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic [CNT_W-1:0]   q_count;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, q_count,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, q_count,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Purpose : synchronous prefetch FIFO with flush; head is presented combinationally.
// Ports   : clk, reset (sync, active-high), push/din write, pop read, flush clears,
//           count occupancy (0..DEPTH), head oldest entry (zero when empty).
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch front end - PC generator, pipelined 1-cycle instruction memory
//           request and a DEPTH-entry prefetch queue feeding decode over valid/ready.
// Ports   : clk, reset (sync, active-high), bus (instr_fetch_unit_if.master):
//           imem_* memory port, redirect_* branch restart, if_* decode handshake, q_count.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter int unsigned       INSTR_W  = IFU_INSTR_W,
    parameter int unsigned       DEPTH    = IFU_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC),
    parameter int unsigned       PC_STEP  = IFU_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned       CNT_W     = ifu_cnt_w(DEPTH);
    localparam int unsigned       ENTRY_W   = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W:0]     occ_c;
    logic               issue_c;
    logic               push_c;
    logic               pop_c;
    logic               valid_c;

    // Credit check: queued entries plus the one in flight must leave room; a same-cycle pop is not counted.
    assign occ_c   = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q);
    assign issue_c = !reset && !bus.redirect_valid && (occ_c < (CNT_W+1)'(DEPTH));

    // A redirect kills the response arriving this cycle and blocks delivery.
    assign push_c  = inflight_q && !bus.redirect_valid;
    assign valid_c = (count != '0) && !bus.redirect_valid;
    assign pop_c   = valid_c && bus.if_ready;

    // PC generator and in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= bus.redirect_pc & ALIGN_MSK;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                fetch_pc    <= fetch_pc + STEP;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .flush (bus.redirect_valid),
        .din   ({inflight_pc, bus.imem_rdata}),
        .count (count),
        .head  (head)
    );

    assign bus.imem_req  = issue_c;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = valid_c;
    assign bus.if_pc     = head[ENTRY_W-1 -: ADDR_W];
    assign bus.if_instr  = head[INSTR_W-1:0];
    assign bus.q_count   = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected PCs are queued by the stimulus,
// monitors pop and compare on every decode transfer.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset1;

    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) bus0 ();
    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) bus1 ();

    instr_fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    instr_fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
    ) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

    // Memory image: each word is its address xor a fixed pattern.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ IFU_NOP;
    endfunction

    always @(posedge clk) if (bus0.imem_req) bus0.imem_rdata <= mem_f(bus0.imem_addr);
    always @(posedge clk) if (bus1.imem_req) bus1.imem_rdata <= mem_f(bus1.imem_addr);

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] e0;
    logic [31:0] e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor for dut0: transfer happens at the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && bus0.if_valid && bus0.if_ready) begin
            if (exp0.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_xfer0: got pc %h, required no transfer", bus0.if_pc);
            end else begin
                e0 = exp0.pop_front();
                chk("pc0", 64'(bus0.if_pc), 64'(e0));
                chk("instr0", 64'(bus0.if_instr), 64'(mem_f(e0)));
            end
        end
        if (!reset && dut0.push_c && (bus0.q_count == CW'(DEPTH))) begin
            fails++;
            $display("FAIL push_full: got q_count %0d with push, required room", bus0.q_count);
        end
    end

    // Monitor for dut1 (wrap instance).
    always begin
        @(negedge clk);
        #2;
        if (!reset1 && bus1.if_valid && bus1.if_ready) begin
            if (exp1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_xfer1: got pc %h, required no transfer", bus1.if_pc);
            end else begin
                e1 = exp1.pop_front();
                chk("pc1", 64'(bus1.if_pc), 64'(e1));
                chk("instr1", 64'(bus1.if_instr), 64'(mem_f(e1)));
            end
        end
    end

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic drain0();
        for (int k = 0; k < 100 && exp0.size() != 0; k++) @(negedge clk);
        if (exp0.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain0: got %0d pending, required 0", exp0.size());
            exp0.delete();
        end
        bus0.if_ready = 1'b0;
    endtask

    task automatic drain1();
        for (int k = 0; k < 100 && exp1.size() != 0; k++) @(negedge clk);
        if (exp1.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain1: got %0d pending, required 0", exp1.size());
            exp1.delete();
        end
        bus1.if_ready = 1'b0;
    endtask

    // Three reset edges, check reset state, release; returns inside cycle 0.
    task automatic do_reset(input logic ready_after);
        reset = 1'b1;
        bus0.if_ready = 1'b0;
        bus0.redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 64'(bus0.imem_req), 64'(0));
        chk("rst_addr", 64'(bus0.imem_addr), 64'(0));
        chk("rst_valid", 64'(bus0.if_valid), 64'(0));
        chk("rst_pc", 64'(bus0.if_pc), 64'(0));
        chk("rst_instr", 64'(bus0.if_instr), 64'(0));
        chk("rst_count", 64'(bus0.q_count), 64'(0));
        reset = 1'b0;
        bus0.if_ready = ready_after;
        #1;
        chk("c0_req", 64'(bus0.imem_req), 64'(1));
        chk("c0_addr", 64'(bus0.imem_addr), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        reset1 = 1'b1;
        bus0.if_ready = 1'b0;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc = '0;
        bus1.if_ready = 1'b0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc = '0;

        // Reset + streaming: 20 consecutive PCs from cycle 2.
        for (int i = 0; i < 20; i++) exp0.push_back(32'(4 * i));
        do_reset(1'b1);
        next_cyc(); #1;
        chk("c1_valid", 64'(bus0.if_valid), 64'(0));
        next_cyc(); #1;
        chk("c2_valid", 64'(bus0.if_valid), 64'(1));
        chk("c2_pc", 64'(bus0.if_pc), 64'(0));
        chk("c2_instr", 64'(bus0.if_instr), 64'(mem_f(32'h0)));
        drain0();

        // Backpressure: queue fills, request stops, then resumes without gap or duplicate.
        do_reset(1'b0);
        repeat (4) next_cyc();
        #1;
        chk("bp_c4_req", 64'(bus0.imem_req), 64'(0));
        repeat (2) next_cyc();
        #1;
        chk("bp_count", 64'(bus0.q_count), 64'(4));
        chk("bp_c6_req", 64'(bus0.imem_req), 64'(0));
        chk("bp_head_pc", 64'(bus0.if_pc), 64'(0));
        next_cyc(); #1;
        chk("bp_c7_req", 64'(bus0.imem_req), 64'(0));
        next_cyc();
        for (int i = 0; i < 10; i++) exp0.push_back(32'(4 * i));
        bus0.if_ready = 1'b1;
        #1;
        chk("bp_c8_req_nocredit", 64'(bus0.imem_req), 64'(0));
        next_cyc(); #1;
        chk("bp_c9_req", 64'(bus0.imem_req), 64'(1));
        chk("bp_c9_addr", 64'(bus0.imem_addr), 64'(32'h10));
        drain0();

        // Redirect at cycle 10 to 0x103 -> 0x100 stream.
        for (int i = 0; i < 8; i++) exp0.push_back(32'(4 * i));
        for (int i = 0; i < 4; i++) exp0.push_back(32'h100 + 32'(4 * i));
        do_reset(1'b1);
        repeat (10) next_cyc();
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc = 32'h103;
        #1;
        chk("rd_c10_valid", 64'(bus0.if_valid), 64'(0));
        chk("rd_c10_req", 64'(bus0.imem_req), 64'(0));
        next_cyc();
        bus0.redirect_valid = 1'b0;
        #1;
        chk("rd_c11_count", 64'(bus0.q_count), 64'(0));
        chk("rd_c11_req", 64'(bus0.imem_req), 64'(1));
        chk("rd_c11_addr", 64'(bus0.imem_addr), 64'(32'h100));
        next_cyc(); #1;
        chk("rd_c12_valid", 64'(bus0.if_valid), 64'(0));
        next_cyc(); #1;
        chk("rd_c13_valid", 64'(bus0.if_valid), 64'(1));
        chk("rd_c13_pc", 64'(bus0.if_pc), 64'(32'h100));
        drain0();

        // Redirect on a full queue with if_ready high: nothing popped, queue empty next cycle.
        do_reset(1'b0);
        repeat (6) next_cyc();
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc = 32'h200;
        bus0.if_ready = 1'b1;
        #1;
        chk("rf_c6_count", 64'(bus0.q_count), 64'(4));
        chk("rf_c6_valid", 64'(bus0.if_valid), 64'(0));
        chk("rf_c6_req", 64'(bus0.imem_req), 64'(0));
        next_cyc();
        bus0.redirect_valid = 1'b0;
        exp0.push_back(32'h200);
        exp0.push_back(32'h204);
        #1;
        chk("rf_c7_count", 64'(bus0.q_count), 64'(0));
        chk("rf_c7_addr", 64'(bus0.imem_addr), 64'(32'h200));
        drain0();

        // Reset with a request in flight: the 0x300 response must never appear.
        do_reset(1'b0);
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc = 32'h300;
        next_cyc();
        bus0.redirect_valid = 1'b0;
        #1;
        chk("ri_c1_req", 64'(bus0.imem_req), 64'(1));
        chk("ri_c1_addr", 64'(bus0.imem_addr), 64'(32'h300));
        next_cyc();
        reset = 1'b1;
        #1;
        chk("ri_rst_req", 64'(bus0.imem_req), 64'(0));
        next_cyc(); #1;
        chk("ri_rst_count", 64'(bus0.q_count), 64'(0));
        chk("ri_rst_valid", 64'(bus0.if_valid), 64'(0));
        next_cyc();
        for (int i = 0; i < 3; i++) exp0.push_back(32'(4 * i));
        reset = 1'b0;
        bus0.if_ready = 1'b1;
        #1;
        chk("ri_rel_addr", 64'(bus0.imem_addr), 64'(0));
        chk("ri_rel_count", 64'(bus0.q_count), 64'(0));
        drain0();

        // PC wrap on the second instance.
        exp1.push_back(32'hFFFF_FFF8);
        exp1.push_back(32'hFFFF_FFFC);
        exp1.push_back(32'h0000_0000);
        exp1.push_back(32'h0000_0004);
        next_cyc();
        reset1 = 1'b0;
        bus1.if_ready = 1'b1;
        #1;
        chk("wr_c0_addr", 64'(bus1.imem_addr), 64'(32'hFFFF_FFF8));
        drain1();

        repeat (3) next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
